mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 43 ++++
 rtl/mem_byte_packer.sv | 25 ++
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-path defines: access size codes, arbiter FSM states and
// the rob/lsb op-to-size mapping.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } mem_op_e;

  function automatic size_e op_size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  // Index of the final byte of an access; the reserved code 3 acts as a word.
  function automatic logic [2:0] size_last(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd0;
      SIZE_HALF: return 3'd1;
      default:   return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_packer.sv
// Merges the incoming RAM byte into the partially assembled word and
// produces the sign/zero-extended load result.
module mem_byte_packer
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  idx_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] word_o,
  output logic [31:0] ext_o
);

  always_comb begin
    word_o = bytes_i;
    word_o[{idx_i, 3'b000} +: 8] = byte_i;
    case (size_i)
      SIZE_BYTE: ext_o = {{24{signed_i & word_o[7]}}, word_o[7:0]};
      SIZE_HALF: ext_o = {{16{signed_i & word_o[15]}}, word_o[15:0]};
      default:   ext_o = word_o;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch, loads and stores.
// Fixed priority store > load > fetch; one byte per cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned FETCH_BYTES = 4,
  parameter logic [1:0]  IO_ADDR_HI  = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_begin,
  output logic        st_finish,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [2:0] FETCH_LAST = 3'(FETCH_BYTES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, last_q, last_d;
  logic [31:0] base_q, base_d, wdata_q, wdata_d, buf_q, buf_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] mem_a_q, mem_a_d, if_data_q, if_data_d, ld_data_q, ld_data_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d, if_done_q, if_done_d, ld_done_q, ld_done_d;
  logic        st_begin_q, st_begin_d, st_finish_q, st_finish_d;

  logic [31:0] merged_word, ext_word, step_addr;
  logic [1:0]  next_idx;
  logic        store_ok;

  mem_byte_packer u_packer (
    .bytes_i (buf_q),
    .byte_i  (mem_din),
    .idx_i   (cnt_q[1:0]),
    .size_i  (size_q),
    .signed_i(signed_q),
    .word_o  (merged_word),
    .ext_o   (ext_word)
  );

  // A store to the UART window waits while its buffer is full.
  assign store_ok  = st_req && !((st_addr[17:16] == IO_ADDR_HI) && io_buffer_full);
  assign step_addr = base_q + 32'(cnt_q) + 32'd1;
  assign next_idx  = cnt_q[1:0] + 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    size_d      = size_q;
    signed_d    = signed_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_data_d   = if_data_q;
    ld_data_d   = ld_data_q;
    if_done_d   = 1'b0;
    ld_done_d   = 1'b0;
    st_begin_d  = 1'b0;
    st_finish_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        buf_d = '0;
        if (store_ok) begin
          state_d    = STORE;
          base_d     = st_addr;
          last_d     = size_last(st_size);
          wdata_d    = st_data;
          mem_a_d    = st_addr;
          mem_dout_d = st_data[7:0];
          mem_wr_d   = 1'b1;
          st_begin_d = 1'b1;
        end else if (!rollback && ld_req) begin
          state_d  = LOAD;
          base_d   = ld_addr;
          last_d   = size_last(ld_size);
          size_d   = ld_size;
          signed_d = ld_signed;
          mem_a_d  = ld_addr;
          mem_wr_d = 1'b0;
        end else if (!rollback && if_req) begin
          state_d  = FETCH;
          base_d   = if_addr;
          last_d   = FETCH_LAST;
          size_d   = SIZE_WORD;
          signed_d = 1'b0;
          mem_a_d  = if_addr;
          mem_wr_d = 1'b0;
        end
      end
      FETCH, LOAD: begin
        if (rollback) begin
          state_d = IDLE;
        end else begin
          buf_d = merged_word;
          if (cnt_q == last_q) begin
            state_d = IDLE;
            if (state_q == FETCH) begin
              if_done_d = 1'b1;
              if_data_d = merged_word;
            end else begin
              ld_done_d = 1'b1;
              ld_data_d = ext_word;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            mem_a_d = step_addr;
          end
        end
      end
      STORE: begin
        if (cnt_q == last_q) begin
          state_d     = IDLE;
          mem_wr_d    = 1'b0;
          st_finish_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_a_d    = step_addr;
          mem_dout_d = wdata_q[{next_idx, 3'b000} +: 8];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_data_q   <= '0;
      ld_data_q   <= '0;
      if_done_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      st_begin_q  <= 1'b0;
      st_finish_q <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_data_q   <= if_data_d;
      ld_data_q   <= ld_data_d;
      if_done_q   <= if_done_d;
      ld_done_q   <= ld_done_d;
      st_begin_q  <= st_begin_d;
      st_finish_q <= st_finish_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q & rdy;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign ld_done   = ld_done_q;
  assign ld_data   = ld_data_q;
  assign st_begin  = st_begin_q;
  assign st_finish = st_finish_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random single transactions
// checked against a transaction-level memory model.
module tb_mem_arbiter;

  localparam int unsigned FETCH_BYTES = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ld_req, ld_signed, ld_done;
  logic [31:0] ld_addr, ld_data;
  logic [1:0]  ld_size, st_size;
  logic        st_req, st_begin, st_finish;
  logic [31:0] st_addr, st_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram     [256];
  logic [7:0]  ref_mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_a = '0, poke_d = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.FETCH_BYTES(FETCH_BYTES), .IO_ADDR_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
    .st_begin(st_begin), .st_finish(st_finish),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM seen by the DUT: combinational read, written only by the DUT or pokes.
  assign mem_din = ram[mem_a[7:0]];
  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (mem_wr) ram[mem_a[7:0]] <= mem_dout;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int unsigned n,
                                           input bit sgn);
    logic [31:0] w = 32'd0;
    for (int unsigned i = 0; i < n; i++)
      w = w + (32'(ref_mem[8'(addr + i)]) << (8 * i));
    if (sgn && n < 4 && w >= (32'd1 << (8 * n - 1)))
      w = w - (32'd1 << (8 * n));
    return w;
  endfunction

  // Caller has raised the request at this negedge; grant is expected at the next edge.
  task automatic check_read(input bit is_fetch, input logic [31:0] addr, input logic [1:0] size,
                            input bit sgn, input int rb_at, input int stall_at);
    int unsigned n;
    logic [31:0] exp;
    n   = is_fetch ? FETCH_BYTES : nbytes(size);
    exp = is_fetch ? ref_load(addr, FETCH_BYTES, 1'b0) : ref_load(addr, n, sgn);
    for (int k = 0; k < int'(n); k++) begin
      @(negedge clk);
      check_eq("rd_addr", mem_a, addr + 32'(k));
      check_eq("rd_no_wr", {31'd0, mem_wr}, 32'd0);
      check_eq("rd_no_pulse", {29'd0, if_done, ld_done, st_finish}, 32'd0);
      if (k == stall_at) begin
        rdy = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check_eq("stall_addr", mem_a, addr + 32'(k));
          check_eq("stall_wr", {31'd0, mem_wr}, 32'd0);
          check_eq("stall_done", {30'd0, if_done, ld_done}, 32'd0);
        end
        rdy = 1'b1;
      end
      if (k == rb_at) begin
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        check_eq("rb_no_done", {30'd0, if_done, ld_done}, 32'd0);
        if (is_fetch) if_req = 1'b0; else ld_req = 1'b0;
        return;
      end
    end
    @(negedge clk);
    if (is_fetch) begin
      check_eq("if_done", {30'd0, if_done, ld_done}, 32'd2);
      check_eq("if_data", if_data, exp);
      if_req = 1'b0;
    end else begin
      check_eq("ld_done", {30'd0, if_done, ld_done}, 32'd1);
      check_eq("ld_data", ld_data, exp);
      ld_req = 1'b0;
    end
  endtask

  task automatic check_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data, input int rb_at, input int stall_at);
    int unsigned n;
    n = nbytes(size);
    for (int k = 0; k < int'(n); k++) begin
      @(negedge clk);
      rollback = 1'b0;
      check_eq("st_addr", mem_a, addr + 32'(k));
      check_eq("st_wr", {31'd0, mem_wr}, 32'd1);
      check_eq("st_dout", {24'd0, mem_dout}, 32'(8'(data >> (8 * k))));
      check_eq("st_begin", {31'd0, st_begin}, (k == 0) ? 32'd1 : 32'd0);
      check_eq("st_no_fin", {31'd0, st_finish}, 32'd0);
      if (k == stall_at) begin
        rdy = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check_eq("st_stall_wr", {31'd0, mem_wr}, 32'd0);
          check_eq("st_stall_addr", mem_a, addr + 32'(k));
        end
        rdy = 1'b1;
      end
      if (k == rb_at) rollback = 1'b1;
    end
    @(negedge clk);
    rollback = 1'b0;
    check_eq("st_wr_off", {31'd0, mem_wr}, 32'd0);
    check_eq("st_finish", {30'd0, st_begin, st_finish}, 32'd1);
    st_req = 1'b0;
    for (int unsigned i = 0; i < n; i++) ref_mem[8'(addr + i)] = 8'(data >> (8 * i));
  endtask

  task automatic raise_fetch(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
  endtask
  task automatic raise_load(input logic [31:0] a, input logic [1:0] s, input bit sg);
    ld_req = 1'b1; ld_addr = a; ld_size = s; ld_signed = sg;
  endtask
  task automatic raise_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    st_req = 1'b1; st_addr = a; st_size = s; st_data = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    bit          sg;
    int          kind, rb, st;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ld_req = 1'b0; ld_addr = '0; ld_size = '0; ld_signed = 1'b0;
    st_req = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'h00, 8'h13); poke(8'h01, 8'h05); poke(8'h02, 8'h00); poke(8'h03, 8'h00);
    poke(8'h20, 8'hFE); poke(8'h21, 8'hFF);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_dout", {24'd0, mem_dout}, 32'd0);
    check_eq("rst_pulses", {27'd0, mem_wr, if_done, ld_done, st_begin, st_finish}, 32'd0);
    check_eq("rst_if_data", if_data, 32'd0);
    check_eq("rst_ld_data", ld_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    raise_fetch(32'h1000);
    check_read(1'b1, 32'h1000, 2'd2, 1'b0, -1, -1);
    check_eq("fetch_word", if_data, 32'h0000_0513);

    // All three requesters at once.
    raise_store(32'h1040, 2'd0, 32'h0000_005A);
    raise_load(32'h1044, 2'd2, 1'b0);
    raise_fetch(32'h1048);
    check_store(32'h1040, 2'd0, 32'h0000_005A, -1, -1);
    check_read(1'b0, 32'h1044, 2'd2, 1'b0, -1, -1);
    check_read(1'b1, 32'h1048, 2'd2, 1'b0, -1, -1);

    raise_load(32'h20, 2'd1, 1'b1);
    check_read(1'b0, 32'h20, 2'd1, 1'b1, -1, -1);
    check_eq("half_signed", ld_data, 32'hFFFF_FFFE);
    raise_load(32'h20, 2'd1, 1'b0);
    check_read(1'b0, 32'h20, 2'd1, 1'b0, -1, -1);
    check_eq("half_unsigned", ld_data, 32'h0000_FFFE);

    io_buffer_full = 1'b1;
    raise_store(32'h0003_0000, 2'd0, 32'h0000_0041);
    repeat (3) begin
      @(negedge clk);
      check_eq("io_blocked", {30'd0, mem_wr, st_begin}, 32'd0);
    end
    io_buffer_full = 1'b0;
    check_store(32'h0003_0000, 2'd0, 32'h0000_0041, -1, -1);

    raise_load(32'h1024, 2'd2, 1'b0);
    check_read(1'b0, 32'h1024, 2'd2, 1'b0, 2, -1);
    raise_fetch(32'h1008);
    check_read(1'b1, 32'h1008, 2'd2, 1'b0, -1, -1);
    raise_store(32'h1050, 2'd2, 32'hA1B2_C3D4);
    check_store(32'h1050, 2'd2, 32'hA1B2_C3D4, 1, -1);
    raise_load(32'h1050, 2'd2, 1'b0);
    check_read(1'b0, 32'h1050, 2'd2, 1'b0, -1, -1);

    raise_fetch(32'h1010);
    check_read(1'b1, 32'h1010, 2'd2, 1'b0, -1, 1);

    // Reset mid-fetch wins over rdy=0 and rollback.
    raise_fetch(32'h1000);
    repeat (2) @(negedge clk);
    rst = 1'b1; rdy = 1'b0; rollback = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check_eq("midrst_out", {28'd0, mem_wr, if_done, ld_done, st_finish}, 32'd0);
    check_eq("midrst_a", mem_a, 32'd0);
    check_eq("midrst_data", if_data, 32'd0);
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    @(negedge clk);
    check_eq("midrst_nodone", {31'd0, if_done}, 32'd0);
    raise_load(32'h1002, 2'd0, 1'b1);
    check_read(1'b0, 32'h1002, 2'd0, 1'b1, -1, -1);

    for (int t = 0; t < 80; t++) begin
      kind = int'($urandom_range(0, 2));
      a    = 32'h1000 + $urandom_range(0, 255);
      s    = 2'($urandom_range(0, 2));
      sg   = 1'($urandom);
      d    = $urandom;
      rb   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nbytes(s) - 1)) : -1;
      st   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nbytes(s) - 1)) : -1;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("idle_pulses", {28'd0, if_done, ld_done, st_begin, st_finish}, 32'd0);
      end
      case (kind)
        0: begin
          if (rb >= 0) rb = int'($urandom_range(0, FETCH_BYTES - 1));
          raise_fetch(a);
          check_read(1'b1, a, 2'd2, 1'b0, rb, st);
        end
        1: begin
          raise_load(a, s, sg);
          check_read(1'b0, a, s, sg, rb, st);
        end
        default: begin
          io_buffer_full = 1'($urandom);
          raise_store(a, s, d);
          check_store(a, s, d, rb, st);
          io_buffer_full = 1'b0;
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
